// File: rtl/shift_register_ctr.sv
// Multi-mode shift/rotate register with saturating shift counter for iterative mul/div.
// One-cycle latency for every command; no backpressure, a command is accepted every cycle.
module shift_register_ctr #(
    parameter int width      = 32,
    parameter int step       = 1,
    parameter int iterations = width / step,
    parameter int cnt_width  = $clog2(iterations + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [2:0]           mode,
    input  logic [width-1:0]     parallelIn,
    input  logic [step-1:0]      serialIn,
    output logic [width-1:0]     parallelOut,
    output logic [step-1:0]      serialOut,
    output logic [cnt_width-1:0] count,
    output logic                 done
);

    localparam logic [cnt_width-1:0] LAST = cnt_width'(iterations);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_SRA  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ROR  = 3'b110;

    logic [width-1:0]     reg_q;
    logic [width-1:0]     shift_d;
    logic [step-1:0]      serial_q;
    logic [step-1:0]      out_d;
    logic [cnt_width-1:0] cnt_q;
    logic                 is_shift;

    // Next register/serial value for the five shift commands; anything else is not a shift.
    always_comb begin
        shift_d  = reg_q;
        out_d    = serial_q;
        is_shift = 1'b1;
        case (mode)
            M_SHL: begin
                shift_d = {reg_q[width-1-step:0], serialIn};
                out_d   = reg_q[width-1 -: step];
            end
            M_SHR: begin
                shift_d = {serialIn, reg_q[width-1:step]};
                out_d   = reg_q[step-1:0];
            end
            M_SRA: begin
                shift_d = {{step{reg_q[width-1]}}, reg_q[width-1:step]};
                out_d   = reg_q[step-1:0];
            end
            M_ROL: begin
                shift_d = {reg_q[width-1-step:0], reg_q[width-1 -: step]};
                out_d   = reg_q[width-1 -: step];
            end
            M_ROR: begin
                shift_d = {reg_q[step-1:0], reg_q[width-1:step]};
                out_d   = reg_q[step-1:0];
            end
            default: is_shift = 1'b0;
        endcase
    end

    assign done = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            reg_q    <= '0;
            serial_q <= '0;
            cnt_q    <= '0;
        end else if (mode == M_LOAD) begin
            reg_q    <= parallelIn;
            serial_q <= '0;
            cnt_q    <= '0;
        end else if (is_shift && !done) begin
            // Shifts stall once the sequence is complete so the count saturates.
            reg_q    <= shift_d;
            serial_q <= out_d;
            cnt_q    <= cnt_q + cnt_width'(1);
        end
    end

    assign parallelOut = reg_q;
    assign serialOut   = serial_q;
    assign count       = cnt_q;

    logic unused_hold;
    assign unused_hold = (mode == M_HOLD);

endmodule

// File: tb/tb_shift_register_ctr.sv
// Directed bench for shift_register_ctr at (8,1), (8,2) and default (32,1) configurations.
module tb_shift_register_ctr;

    typedef struct {
        string       tag;
        logic [31:0] r;
        logic [1:0]  so;
        int          cnt;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passes = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n = 1'b1, a_clear = 1'b0, a_si = 1'b0, a_so, a_done;
    logic [2:0] a_mode = 3'b000;
    logic [7:0] a_pin = '0, a_po;
    logic [3:0] a_count;

    logic       b_rst_n = 1'b1, b_clear = 1'b0, b_done;
    logic [1:0] b_si = '0, b_so;
    logic [2:0] b_mode = 3'b000;
    logic [7:0] b_pin = '0, b_po;
    logic [2:0] b_count;

    logic        c_rst_n = 1'b1, c_clear = 1'b0, c_si = 1'b0, c_so, c_done;
    logic [2:0]  c_mode = 3'b000;
    logic [31:0] c_pin = '0, c_po;
    logic [5:0]  c_count;

    shift_register_ctr #(.width(8), .step(1)) u_a (
        .clk(clk), .rst_n(a_rst_n), .clear(a_clear), .mode(a_mode),
        .parallelIn(a_pin), .serialIn(a_si), .parallelOut(a_po),
        .serialOut(a_so), .count(a_count), .done(a_done)
    );

    shift_register_ctr #(.width(8), .step(2)) u_b (
        .clk(clk), .rst_n(b_rst_n), .clear(b_clear), .mode(b_mode),
        .parallelIn(b_pin), .serialIn(b_si), .parallelOut(b_po),
        .serialOut(b_so), .count(b_count), .done(b_done)
    );

    shift_register_ctr u_c (
        .clk(clk), .rst_n(c_rst_n), .clear(c_clear), .mode(c_mode),
        .parallelIn(c_pin), .serialIn(c_si), .parallelOut(c_po),
        .serialOut(c_so), .count(c_count), .done(c_done)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Drive one command on one instance, queue its expected result, then check after the edge.
    task automatic op(input int inst, input logic rn, input logic clr, input logic [2:0] md,
                      input logic [31:0] pin, input logic [1:0] sin, input string tag,
                      input logic [31:0] er, input logic [1:0] eso, input int ecnt,
                      input logic edone);
        exp_t        e;
        logic [31:0] ro, co;
        logic [1:0]  soo;
        logic        dno;
        a_rst_n = 1'b1; a_clear = 1'b0; a_mode = 3'b000;
        b_rst_n = 1'b1; b_clear = 1'b0; b_mode = 3'b000;
        c_rst_n = 1'b1; c_clear = 1'b0; c_mode = 3'b000;
        case (inst)
            0: begin a_rst_n = rn; a_clear = clr; a_mode = md; a_pin = pin[7:0]; a_si = sin[0]; end
            1: begin b_rst_n = rn; b_clear = clr; b_mode = md; b_pin = pin[7:0]; b_si = sin; end
            default: begin c_rst_n = rn; c_clear = clr; c_mode = md; c_pin = pin; c_si = sin[0]; end
        endcase
        e.tag = tag; e.r = er; e.so = eso; e.cnt = ecnt; e.done = edone;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        case (inst)
            0:       begin ro = 32'(a_po); soo = 2'(a_so); co = 32'(a_count); dno = a_done; end
            1:       begin ro = 32'(b_po); soo = b_so;     co = 32'(b_count); dno = b_done; end
            default: begin ro = c_po;      soo = 2'(c_so); co = 32'(c_count); dno = c_done; end
        endcase
        cmp({e.tag, ".reg"},   ro,        e.r);
        cmp({e.tag, ".sout"},  32'(soo),  32'(e.so));
        cmp({e.tag, ".count"}, co,        32'(e.cnt));
        cmp({e.tag, ".done"},  32'(dno),  32'(e.done));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m;
        logic        mso;

        // Reset all three instances.
        op(0, 0, 0, 3'b000, 0, 0, "rst_a", 32'h00, 2'b00, 0, 0);
        op(1, 0, 0, 3'b000, 0, 0, "rst_b", 32'h00, 2'b00, 0, 0);
        op(2, 0, 0, 3'b000, 0, 0, "rst_c", 32'h00, 2'b00, 0, 0);

        // Reset and clear after a load.
        op(0, 1, 0, 3'b001, 32'hA5, 0, "load_a5", 32'hA5, 2'b00, 0, 0);
        op(0, 0, 0, 3'b000, 0, 0, "rst_after_load", 32'h00, 2'b00, 0, 0);
        op(0, 1, 0, 3'b001, 32'hA5, 0, "load_a5_2", 32'hA5, 2'b00, 0, 0);
        op(0, 1, 1, 3'b000, 0, 0, "clear_after_load", 32'h00, 2'b00, 0, 0);
        op(0, 1, 0, 3'b001, 32'hA5, 0, "load_a5_3", 32'hA5, 2'b00, 0, 0);
        a_rst_n = 1'b0;
        #2;
        cmp("sync_rst_probe.reg", 32'(a_po), 32'hA5);
        op(0, 0, 0, 3'b000, 0, 0, "sync_rst_edge", 32'h00, 2'b00, 0, 0);

        // Logical shifts, step 1.
        op(0, 1, 0, 3'b001, 32'h81, 0, "load_81", 32'h81, 2'b00, 0, 0);
        op(0, 1, 0, 3'b010, 0, 2'b01, "shl", 32'h03, 2'b01, 1, 0);
        op(0, 1, 0, 3'b011, 0, 2'b00, "shr", 32'h01, 2'b01, 2, 0);

        // Arithmetic and rotates, step 2.
        op(1, 1, 0, 3'b001, 32'h90, 0, "load_90", 32'h90, 2'b00, 0, 0);
        op(1, 1, 0, 3'b100, 0, 2'b11, "sra2", 32'hE4, 2'b00, 1, 0);
        op(1, 1, 0, 3'b001, 32'h93, 0, "load_93", 32'h93, 2'b00, 0, 0);
        op(1, 1, 0, 3'b101, 0, 2'b00, "rol2", 32'h4E, 2'b10, 1, 0);
        op(1, 1, 0, 3'b110, 0, 2'b00, "ror2", 32'h93, 2'b10, 2, 0);

        // Counter saturation: ten shl on an 8-bit, 8-iteration register.
        op(0, 1, 0, 3'b001, 32'h01, 0, "load_01", 32'h01, 2'b00, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            op(0, 1, 0, 3'b010, 0, 2'b00, $sformatf("sat_shl%0d", k),
               (k < 8) ? (32'h1 << k) : 32'h0, (k >= 8) ? 2'b01 : 2'b00,
               (k < 8) ? k : 8, (k >= 8));
        end

        // Clear beats a simultaneous load; restart; reserved mode holds.
        op(0, 1, 1, 3'b001, 32'h3C, 0, "clear_vs_load", 32'h00, 2'b00, 0, 0);
        op(0, 1, 0, 3'b001, 32'h3C, 0, "reload_3c", 32'h3C, 2'b00, 0, 0);
        for (int k = 0; k < 3; k++)
            op(0, 1, 0, 3'b111, 32'hFF, 2'b01, $sformatf("reserved%0d", k), 32'h3C, 2'b00, 0, 0);
        op(0, 1, 0, 3'b000, 32'hFF, 2'b01, "hold", 32'h3C, 2'b00, 0, 0);

        // Default parameters: 32 arithmetic shifts of 0x8000_0001.
        op(2, 1, 0, 3'b001, 32'h8000_0001, 0, "load_c", 32'h8000_0001, 2'b00, 0, 0);
        m = 32'h8000_0001;
        for (int k = 1; k <= 32; k++) begin
            mso = m[0];
            m   = 32'($signed(m) >>> 1);
            op(2, 1, 0, 3'b100, 0, 2'b01, $sformatf("sra32_%0d", k),
               m, {1'b0, mso}, k, (k == 32));
        end
        op(2, 1, 0, 3'b100, 0, 2'b00, "sra32_extra", 32'hFFFF_FFFF, 2'b01, 32, 1);
        op(2, 1, 0, 3'b001, 32'h1234_5678, 0, "load_after_done", 32'h1234_5678, 2'b00, 0, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
